// File: rtl/mux_n_1_hs.sv
// N:1 multiplexer into a single output register, select by s (MODE 0) or round-robin (MODE 1).
// Latency: a word accepted at edge k is on y with y_valid=1 after edge k; one word/cycle sustained.
// Backpressure: while y is full and y_ready=0 all a_ready are low and y/grant/rr_ptr hold.
module mux_n_1_hs #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  a,
  input  logic [N-1:0]    a_valid,
  output logic [N-1:0]    a_ready,
  input  logic [SW-1:0]   s,
  output logic [W-1:0]    y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [SW-1:0]   grant
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_y;
  logic [SW-1:0]   r_grant;
  logic [SW-1:0]   r_rr_ptr;

  logic            w_load;
  logic            w_hit;
  logic [SW-1:0]   w_sel;
  logic [W-1:0]    w_sel_dat;
  logic [SW-1:0]   w_rr_nxt;
  logic [2*N-1:0]  w_rot;

  // Valid vector rotated so that bit 0 is the channel at rr_ptr
  assign w_rot = {a_valid, a_valid} >> r_rr_ptr;

  // Candidate selection: explicit select, or first valid channel at/after rr_ptr
  always_comb begin
    int idx;
    idx   = 0;
    w_sel = '0;
    w_hit = 1'b0;
    if (MODE == 0) begin
      w_sel = s;
      // s beyond the last channel matches nothing, so it never hits
      for (int i = 0; i < N; i++) begin
        if (s == SW'(i)) w_hit = a_valid[i];
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!w_hit && w_rot[k]) begin
          w_hit = 1'b1;
          idx   = int'(r_rr_ptr) + k;
          if (idx >= N) idx = idx - N;
          w_sel = SW'(idx);
        end
      end
    end
  end

  // Data of the selected channel
  always_comb begin
    w_sel_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (w_sel == SW'(i)) w_sel_dat = a[i*W +: W];
    end
  end

  // Pointer moves to the channel after the one just granted
  assign w_rr_nxt = (w_sel == SW'(N - 1)) ? '0 : w_sel + SW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state: fill when a word is taken, drain when the slot frees with nothing to take
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   w_state_nxt = w_hit ? FULL : EMPTY;
      FULL:    if (y_ready) w_state_nxt = w_hit ? FULL : EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Outputs decoded from state; the slot can load when empty or being popped
  always_comb begin
    y_valid = (r_state == FULL);
    w_load  = (r_state == EMPTY) | (y_valid & y_ready);
    a_ready = '0;
    for (int i = 0; i < N; i++) begin
      a_ready[i] = rst_n & w_load & w_hit & (w_sel == SW'(i));
    end
  end

  // Output word, grant and arbitration pointer; all hold unless a word is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y      <= '0;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else if (w_load && w_hit) begin
      r_y     <= w_sel_dat;
      r_grant <= w_sel;
      if (MODE == 1) r_rr_ptr <= w_rr_nxt;
    end
  end

  assign y     = r_y;
  assign grant = r_grant;

endmodule

// File: tb/tb_mux_n_1_hs.sv
// Directed bench for mux_n_1_hs: select mode (N=4), round-robin mode (N=4), select mode with N=3.
// Inputs are driven 2 time units after the rising edge; outputs are sampled before the next edge.
// Summary line reports total comparisons and failures.
module tb_mux_n_1_hs;

  logic clk;
  logic rst_n;

  // DUT 0: N=4, MODE 0
  logic [31:0] a0;
  logic [3:0]  av0, ar0;
  logic [1:0]  s0, g0;
  logic [7:0]  y0;
  logic        yv0, yr0;

  // DUT 1: N=4, MODE 1
  logic [31:0] a1;
  logic [3:0]  av1, ar1;
  logic [1:0]  s1, g1;
  logic [7:0]  y1;
  logic        yv1, yr1;

  // DUT 2: N=3, MODE 0
  logic [23:0] a2;
  logic [2:0]  av2, ar2;
  logic [1:0]  s2, g2;
  logic [7:0]  y2;
  logic        yv2, yr2;

  int n_checks;
  int n_errors;

  mux_n_1_hs #(.N(4), .W(8), .MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a(a0), .a_valid(av0), .a_ready(ar0), .s(s0),
    .y(y0), .y_valid(yv0), .y_ready(yr0), .grant(g0)
  );

  mux_n_1_hs #(.N(4), .W(8), .MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .a_valid(av1), .a_ready(ar1), .s(s1),
    .y(y1), .y_valid(yv1), .y_ready(yr1), .grant(g1)
  );

  mux_n_1_hs #(.N(3), .W(8), .MODE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .a_valid(av2), .a_ready(ar2), .s(s2),
    .y(y2), .y_valid(yv2), .y_ready(yr2), .grant(g2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] exp_y [4];
  logic [7:0] rr_y  [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_y[0] = 8'h11; exp_y[1] = 8'h22; exp_y[2] = 8'h33; exp_y[3] = 8'h44;
    rr_y[0]  = 8'hA0; rr_y[1]  = 8'hA1; rr_y[2]  = 8'hA2; rr_y[3]  = 8'hA3;

    rst_n = 1'b0;
    a0 = 32'h44332211; av0 = 4'b1111; s0 = 2'd0; yr0 = 1'b1;
    a1 = 32'hA3A2A1A0; av1 = 4'b1111; s1 = 2'd0; yr1 = 1'b1;
    a2 = 24'h332211;   av2 = 3'b111;  s2 = 2'd0; yr2 = 1'b1;

    // Reset held with valid inputs: nothing may be accepted
    tick();
    tick();
    check("rst_ar0", {28'd0, ar0}, 32'h0);
    check("rst_ar1", {28'd0, ar1}, 32'h0);
    check("rst_ar2", {29'd0, ar2}, 32'h0);
    check("rst_yv0", {31'd0, yv0}, 32'h0);
    check("rst_y0",  {24'd0, y0},  32'h0);

    // Test 1: release with nothing valid, idle for 10 cycles
    av0 = 4'b0000; av1 = 4'b0000; av2 = 3'b000;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_y",  {24'd0, y0},  32'h0);
      check("idle_yv", {31'd0, yv0}, 32'h0);
      check("idle_g",  {30'd0, g0},  32'h0);
      check("idle_ar", {28'd0, ar0}, 32'h0);
    end

    // Test 2: select by s, one word per cycle, result one cycle later
    av0 = 4'b1111; yr0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0 = 2'(i);
      #1;
      check("sel_ar", {28'd0, ar0}, 32'h1 << i);
      tick();
      check("sel_y",  {24'd0, y0},  {24'd0, exp_y[i]});
      check("sel_g",  {30'd0, g0},  i);
      check("sel_yv", {31'd0, yv0}, 32'h1);
    end

    // Test 3: load channel 2, then stall 5 cycles with s moved to 0 mid-stall
    s0 = 2'd2; av0 = 4'b0100; yr0 = 1'b1;
    tick();
    check("bp_load_y", {24'd0, y0}, 32'h33);
    yr0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        s0 = 2'd0; av0 = 4'b0001;
      end
      #1;
      check("bp_ar", {28'd0, ar0}, 32'h0);
      tick();
      check("bp_y",  {24'd0, y0},  32'h33);
      check("bp_g",  {30'd0, g0},  32'h2);
      check("bp_yv", {31'd0, yv0}, 32'h1);
    end
    yr0 = 1'b1;
    #1;
    check("bp_rel_ar", {28'd0, ar0}, 32'h1);
    tick();
    check("bp_rel_y",  {24'd0, y0},  32'h11);
    check("bp_rel_g",  {30'd0, g0},  32'h0);
    check("bp_rel_yv", {31'd0, yv0}, 32'h1);
    av0 = 4'b0000;
    tick();
    check("bp_drain_yv", {31'd0, yv0}, 32'h0);

    // Test 4: round-robin with all channels valid
    av1 = 4'b1111; yr1 = 1'b1;
    #1;
    check("rr_ar_first", {28'd0, ar1}, 32'h1);
    for (int c = 0; c < 8; c++) begin
      tick();
      check("rr_g",  {30'd0, g1},  c % 4);
      check("rr_y",  {24'd0, y1},  {24'd0, rr_y[c % 4]});
      check("rr_yv", {31'd0, yv1}, 32'h1);
    end

    // Test 5: idle channels skipped, then drain
    av1 = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("skip_g",  {30'd0, g1},  (c % 2 == 0) ? 32'd1 : 32'd3);
      check("skip_yv", {31'd0, yv1}, 32'h1);
    end
    av1 = 4'b0000;
    tick();
    check("skip_drain_yv", {31'd0, yv1}, 32'h0);
    check("skip_drain_y",  {24'd0, y1},  32'hA3);
    check("skip_drain_g",  {30'd0, g1},  32'h3);

    // Test 6: N=3 with out-of-range select never accepts
    av2 = 3'b111; s2 = 2'd3; yr2 = 1'b1;
    #1;
    check("n3_s3_ar", {29'd0, ar2}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("n3_s3_yv", {31'd0, yv2}, 32'h0);
    end
    s2 = 2'd1;
    #1;
    check("n3_s1_ar", {29'd0, ar2}, 32'h2);
    tick();
    check("n3_s1_y",  {24'd0, y2},  32'h22);
    check("n3_s1_yv", {31'd0, yv2}, 32'h1);
    yr2 = 1'b0;

    // Asynchronous reset between clock edges while full
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_y2",  {24'd0, y2},  32'h0);
    check("arst_yv2", {31'd0, yv2}, 32'h0);
    check("arst_g2",  {30'd0, g2},  32'h0);
    check("arst_ar2", {29'd0, ar2}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
